// File: rtl/cm0_dap_jt_cdc_rx.sv
// cm0_dap_jt_cdc_rx: receive side of the DAP JTAG clock-domain-crossing REQ/ACK data interface.
// Optional macro CM0_DAP_JT_CDC_RX_SYNC3_EN selects a 3-flop REQ synchroniser (default 2 flops).
module cm0_dap_jt_cdc_rx #(
    parameter int DW      = 32,
    parameter bit PRESENT = 1'b1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQASYNC,
    input  logic [DW-1:0] DATAASYNC,
    output logic          ACK,
    output logic [DW-1:0] RXDATA,
    output logic          RXVALID,
    input  logic          RXREADY,
    output logic          PROTERR
);

    // state | meaning
    // IDLE  | waiting for synchronised REQ, ACK low
    // VALID | word captured and offered to the local consumer
    // ACKHI | word accepted, ACK held high until REQ falls
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACKHI = 2'd2
    } state_t;

`ifdef CM0_DAP_JT_CDC_RX_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    generate
        if (PRESENT) begin : g_rx
            state_t          r_state;
            state_t          w_state_nxt;
            logic [SYNC_N-1:0] r_sync;
            logic            w_req_s;
            logic            w_capture;
            logic            w_ack_nxt;
            logic            w_valid_nxt;
            logic            w_perr_set;
            logic            r_ack;
            logic            r_valid;
            logic            r_proterr;
            logic [DW-1:0]   r_data;

            assign w_req_s = r_sync[SYNC_N-1];

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_N-2:0], REQASYNC};
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_state   <= ST_IDLE;
                    r_ack     <= 1'b0;
                    r_valid   <= 1'b0;
                    r_proterr <= 1'b0;
                    r_data    <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_ack   <= w_ack_nxt;
                    r_valid <= w_valid_nxt;
                    if (w_perr_set) begin
                        r_proterr <= 1'b1;
                    end
                    // DATAASYNC is only looked at once req_s has settled high
                    if (w_capture) begin
                        r_data <= DATAASYNC;
                    end
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_ack_nxt   = r_ack;
                w_valid_nxt = r_valid;
                w_capture   = 1'b0;
                w_perr_set  = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        w_ack_nxt   = 1'b0;
                        w_valid_nxt = 1'b0;
                        if (w_req_s) begin
                            w_capture   = 1'b1;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = ST_VALID;
                        end
                    end
                    ST_VALID: begin
                        w_ack_nxt   = 1'b0;
                        w_valid_nxt = 1'b1;
                        // REQ dropped before ACK: flag it but still deliver the word
                        if (!w_req_s) begin
                            w_perr_set = 1'b1;
                        end
                        if (RXREADY) begin
                            w_valid_nxt = 1'b0;
                            w_ack_nxt   = 1'b1;
                            w_state_nxt = ST_ACKHI;
                        end
                    end
                    ST_ACKHI: begin
                        w_ack_nxt   = 1'b1;
                        w_valid_nxt = 1'b0;
                        if (!w_req_s) begin
                            w_ack_nxt   = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: begin
                        w_ack_nxt   = 1'b0;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end

            assign ACK     = r_ack;
            assign RXVALID = r_valid;
            assign RXDATA  = r_data;
            assign PROTERR = r_proterr;
        end else begin : g_absent
            assign ACK     = 1'b0;
            assign RXVALID = 1'b0;
            assign RXDATA  = '0;
            assign PROTERR = 1'b0;
        end
    endgenerate

endmodule
